jtag_l2_test: RTL and testbench

//  - IEEE 1149.1 TAP giving a debug host word read/write access to a small on-chip L2 SRAM.
//  - Sits between the chip JTAG pins and the L2 array. Used to bring up and test L2 from JTAG alone.
//  - TAP logic runs in the TCK domain; the SRAM and its bus side run in the clk_i domain.
//  - The two domains talk through a toggle request/acknowledge handshake.

---
 rtl/jtag_l2_pkg.sv | 31 +++
 rtl/jtag_l2_tap.sv | 104 ++++++++++
 rtl/jtag_l2_test.sv | 117 +++++++++++
 tb/tb_jtag_l2_test.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_l2_pkg.sv
// Shared constants for the JTAG-to-L2 test access port: IR opcodes, DR widths,
// MEMREG field offsets and the TAP controller state encoding.
package jtag_l2_pkg;

  localparam int unsigned IR_LEN = 4;

  localparam logic [IR_LEN-1:0] IR_IDCODE  = 4'b0010;
  localparam logic [IR_LEN-1:0] IR_CONFREG = 4'b0110;
  localparam logic [IR_LEN-1:0] IR_MEMREG  = 4'b0100;
  localparam logic [IR_LEN-1:0] IR_BYPASS  = 4'b1111;
  localparam logic [IR_LEN-1:0] IR_CAPTURE = 4'b0101;

  localparam int unsigned IDCODE_W  = 32;
  localparam int unsigned CONFREG_W = 9;
  localparam int unsigned MEMREG_W  = 66;
  localparam int unsigned BYPASS_W  = 1;

  localparam int unsigned MEM_WE    = 0;
  localparam int unsigned MEM_ADDR  = 1;
  localparam int unsigned MEM_WDATA = 33;
  localparam int unsigned MEM_GO    = 65;

  localparam logic [2:0] SRC_JTAG = 3'b001;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_e;

endpackage

// File: rtl/jtag_l2_tap.sv
// IEEE 1149.1 TAP: state machine, instruction register, IDCODE/CONFREG/MEMREG/BYPASS
// data registers and the falling-edge TDO driver. Runs entirely on TCK.
module jtag_l2_tap
  import jtag_l2_pkg::*;
#(
  parameter logic [31:0] IDCODE_VAL = 32'h1010_2001,
  parameter int unsigned IR_W       = IR_LEN
) (
  input  logic                tck,
  input  logic                trst_n,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  input  logic [MEMREG_W-1:0] mem_capture,
  output logic [MEMREG_W-1:0] mem_shift,
  output logic                mem_update,
  output logic                tlr,
  output logic                jtag_sel
);

  tap_state_e state, next_state;
  logic [IR_W-1:0]      ir, ir_shift;
  logic [MEMREG_W-1:0]  dr;
  logic [CONFREG_W-1:0] confreg;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) state <= TLR;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      TLR:      next_state = tms ? TLR      : RTI;
      RTI:      next_state = tms ? SEL_DR   : RTI;
      SEL_DR:   next_state = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   next_state = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: next_state = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: next_state = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: next_state = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: next_state = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   next_state = tms ? SEL_DR   : RTI;
      SEL_IR:   next_state = tms ? TLR      : CAP_IR;
      CAP_IR:   next_state = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: next_state = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: next_state = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: next_state = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: next_state = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   next_state = tms ? SEL_DR   : RTI;
      default:  next_state = TLR;
    endcase
  end

  // One shared shift register; shorter DRs insert TDI at their own MSB.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir       <= IR_IDCODE;
      ir_shift <= '0;
      dr       <= '0;
      confreg  <= '0;
    end else begin
      unique case (state)
        TLR: begin
          ir      <= IR_IDCODE;
          confreg <= '0;
        end
        CAP_IR:   ir_shift <= IR_CAPTURE;
        SHIFT_IR: ir_shift <= {tdi, ir_shift[IR_W-1:1]};
        UPD_IR:   ir       <= ir_shift;
        CAP_DR: begin
          case (ir)
            IR_IDCODE:  dr <= {{(MEMREG_W-IDCODE_W){1'b0}}, IDCODE_VAL};
            IR_CONFREG: dr <= {{(MEMREG_W-CONFREG_W){1'b0}}, confreg};
            IR_MEMREG:  dr <= mem_capture;
            default:    dr <= '0;
          endcase
        end
        SHIFT_DR: begin
          case (ir)
            IR_IDCODE:  dr <= {{(MEMREG_W-IDCODE_W){1'b0}}, tdi, dr[IDCODE_W-1:1]};
            IR_CONFREG: dr <= {{(MEMREG_W-CONFREG_W){1'b0}}, tdi, dr[CONFREG_W-1:1]};
            IR_MEMREG:  dr <= {tdi, dr[MEMREG_W-1:1]};
            default:    dr <= {{(MEMREG_W-BYPASS_W){1'b0}}, tdi};
          endcase
        end
        UPD_DR: if (ir == IR_CONFREG) confreg <= dr[CONFREG_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n)                tdo <= 1'b0;
    else if (state == SHIFT_IR) tdo <= ir_shift[0];
    else if (state == SHIFT_DR) tdo <= dr[0];
    else                        tdo <= 1'b0;
  end

  assign mem_shift  = dr;
  assign mem_update = (state == UPD_DR) && (ir == IR_MEMREG);
  assign tlr        = (state == TLR);
  assign jtag_sel   = (confreg[3:1] == SRC_JTAG);

endmodule

// File: rtl/jtag_l2_test.sv
// JTAG access to a small L2 SRAM: TAP on TCK, SRAM on clk_i, joined by a
// toggle request/acknowledge handshake with 2-flop synchronizers on each side.
module jtag_l2_test
  import jtag_l2_pkg::*;
#(
  parameter logic [31:0] IDCODE_VAL = 32'h1010_2001,
  parameter int unsigned L2_WORDS   = 256,
  parameter int unsigned IR_W       = 4
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic jtag_tck_i,
  input  logic jtag_trst_ni,
  input  logic jtag_tms_i,
  input  logic jtag_tdi_i,
  output logic jtag_tdo_o
);

  localparam int unsigned AW = $clog2(L2_WORDS);

  logic [MEMREG_W-1:0] mem_capture, mem_shift;
  logic                mem_update, tlr, jtag_sel;

  logic        req_tgl, pending, valid, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata, rdata_hold;
  logic        ack_s1, ack_s2, ack_prev;

  logic        req_s1, req_s2, req_prev, acc_d, ack_tgl, do_acc;
  logic [1:0]  settle;
  logic [31:0] rdata;
  logic [AW-1:0] idx;
  logic [31:0] mem [L2_WORDS];

  jtag_l2_tap #(
    .IDCODE_VAL (IDCODE_VAL),
    .IR_W       (IR_W)
  ) u_tap (
    .tck         (jtag_tck_i),
    .trst_n      (jtag_trst_ni),
    .tms         (jtag_tms_i),
    .tdi         (jtag_tdi_i),
    .tdo         (jtag_tdo_o),
    .mem_capture (mem_capture),
    .mem_shift   (mem_shift),
    .mem_update  (mem_update),
    .tlr         (tlr),
    .jtag_sel    (jtag_sel)
  );

  assign mem_capture = {1'b0, rdata_hold, cmd_addr, valid};

  // Acks are honoured only while pending, so a TAP reset mid-access discards the late ack.
  always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
    if (!jtag_trst_ni) begin
      req_tgl    <= 1'b0;
      pending    <= 1'b0;
      valid      <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      rdata_hold <= '0;
      ack_s1     <= 1'b0;
      ack_s2     <= 1'b0;
      ack_prev   <= 1'b0;
    end else begin
      ack_s1   <= ack_tgl;
      ack_s2   <= ack_s1;
      ack_prev <= ack_s2;
      if (tlr) begin
        pending    <= 1'b0;
        valid      <= 1'b0;
        rdata_hold <= '0;
      end else if (pending && (ack_s2 != ack_prev)) begin
        pending    <= 1'b0;
        valid      <= 1'b1;
        rdata_hold <= rdata;
      end else if (mem_update && mem_shift[MEM_GO] && jtag_sel && !pending) begin
        cmd_we    <= mem_shift[MEM_WE];
        cmd_addr  <= mem_shift[MEM_ADDR +: 32];
        cmd_wdata <= mem_shift[MEM_WDATA +: 32];
        req_tgl   <= ~req_tgl;
        pending   <= 1'b1;
        valid     <= 1'b0;
      end
    end
  end

  // After rst_n the synchronized request level is adopted silently, so a request
  // in flight across the reset is dropped rather than replayed.
  assign do_acc = (&settle) && (req_s2 != req_prev);
  assign idx    = cmd_addr[2 +: AW];

  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      req_s1   <= 1'b0;
      req_s2   <= 1'b0;
      req_prev <= 1'b0;
      settle   <= '0;
      acc_d    <= 1'b0;
      ack_tgl  <= 1'b0;
      rdata    <= '0;
    end else begin
      req_s1   <= req_tgl;
      req_s2   <= req_s1;
      req_prev <= req_s2;
      if (!(&settle)) settle <= settle + 2'd1;
      acc_d <= do_acc;
      if (acc_d) ack_tgl <= ~ack_tgl;
      if (do_acc && !cmd_we) rdata <= mem[idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_acc && cmd_we) mem[idx] <= cmd_wdata;
  end

endmodule

// File: tb/tb_jtag_l2_test.sv
// Directed bench for jtag_l2_test: drives TCK/TMS/TDI from tasks and checks IDCODE,
// BYPASS, CONFREG and MEMREG read/write behaviour against hand-computed values.
module tb_jtag_l2_test;

  localparam realtime CLK_PERIOD = 30517ns;
  localparam realtime TCK_HALF   = 50ns;
  localparam int unsigned POLL_MAX = 200;

  logic clk_i = 1'b0;
  logic rst_n = 1'b1;
  logic tck   = 1'b0;
  logic trst_n = 1'b0;
  logic tms   = 1'b1;
  logic tdi   = 1'b0;
  logic tdo;

  int vectors = 0;
  int miscompares = 0;

  jtag_l2_test #(
    .IDCODE_VAL (32'h1010_2001),
    .L2_WORDS   (256),
    .IR_W       (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .jtag_tck_i   (tck),
    .jtag_trst_ni (trst_n),
    .jtag_tms_i   (tms),
    .jtag_tdi_i   (tdi),
    .jtag_tdo_o   (tdo)
  );

  initial begin : tb_clk_gen
    forever #(CLK_PERIOD/2) clk_i = ~clk_i;
  end

  // TDO is sampled mid-low-phase, well away from both TCK edges.
  task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
    tms = tms_v;
    tdi = tdi_v;
    #25ns;
    tdo_v = tdo;
    #25ns;
    tck = 1'b1;
    #(TCK_HALF);
    tck = 1'b0;
  endtask

  task automatic tms_step(input logic v);
    logic d;
    tck_cycle(v, 1'b0, d);
  endtask

  task automatic shift_ir(input logic [3:0] code, output logic [3:0] cap);
    logic b;
    tms_step(1'b1); tms_step(1'b1); tms_step(1'b0); tms_step(1'b0);
    for (int i = 0; i < 4; i++) begin
      tck_cycle(i == 3, code[i], b);
      cap[i] = b;
    end
    tms_step(1'b1); tms_step(1'b0);
  endtask

  task automatic shift_dr(input logic [65:0] din, input int unsigned len, output logic [65:0] cap);
    logic b;
    cap = '0;
    tms_step(1'b1); tms_step(1'b0); tms_step(1'b0);
    for (int unsigned i = 0; i < len; i++) begin
      tck_cycle(i == len - 1, din[i], b);
      cap[i] = b;
    end
    tms_step(1'b1); tms_step(1'b0);
  endtask

  task automatic mem_scan(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic go, output logic [65:0] cap);
    shift_dr({go, wdata, addr, we}, 66, cap);
  endtask

  task automatic poll_valid(output logic [65:0] cap, output bit ok);
    ok = 1'b0;
    cap = '0;
    for (int unsigned n = 0; n < POLL_MAX; n++) begin
      mem_scan(1'b0, 32'h0, 32'h0, 1'b0, cap);
      if (cap[0] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [65:0] cap;
    logic [3:0]  irc;
    trst_n = 1'b0;
    rst_n  = 1'b1;
    #100ns;
    vectors++;
    if (tdo !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tdo: got %b expected 0", tdo);
    end
    repeat (3) @(posedge clk_i);
    #1ns;
    rst_n  = 1'b0;
    trst_n = 1'b1;
    repeat (5) tms_step(1'b1);
    tms_step(1'b0);
    repeat (4) @(posedge clk_i);
    #1ns;
    shift_dr('0, 32, cap);
    vectors++;
    if (cap[31:0] !== 32'h1010_2001) begin
      miscompares++;
      $display("FAIL default_idcode: got %h expected 10102001", cap[31:0]);
    end
    shift_ir(4'b0010, irc);
    vectors++;
    if (irc !== 4'b0101) begin
      miscompares++;
      $display("FAIL ir_capture: got %b expected 0101", irc);
    end
    shift_dr('0, 32, cap);
    vectors++;
    if (cap[31:0] !== 32'h1010_2001) begin
      miscompares++;
      $display("FAIL idcode: got %h expected 10102001", cap[31:0]);
    end
    vectors++;
    if (tdo !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_tdo: got %b expected 0", tdo);
    end
  endtask

  task automatic test_bypass();
    logic [65:0] cap;
    logic [3:0]  irc;
    shift_ir(4'b1111, irc);
    shift_dr({58'h0, 8'hA5}, 9, cap);
    vectors++;
    if (cap[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_capture: got %b expected 0", cap[0]);
    end
    vectors++;
    if (cap[8:1] !== 8'hA5) begin
      miscompares++;
      $display("FAIL bypass_a5: got %h expected a5", cap[8:1]);
    end
    shift_ir(4'b0011, irc);
    shift_dr({58'h0, 8'h3C}, 9, cap);
    vectors++;
    if (cap[8:0] !== 9'h078) begin
      miscompares++;
      $display("FAIL bypass_unused_code: got %h expected 078", cap[8:0]);
    end
  endtask

  task automatic test_confreg();
    logic [65:0] cap;
    logic [3:0]  irc;
    shift_ir(4'b0110, irc);
    shift_dr({57'h0, 9'h002}, 9, cap);
    vectors++;
    if (cap[8:0] !== 9'h000) begin
      miscompares++;
      $display("FAIL confreg_reset: got %h expected 000", cap[8:0]);
    end
    shift_dr({57'h0, 9'h002}, 9, cap);
    vectors++;
    if (cap[8:0] !== 9'h002) begin
      miscompares++;
      $display("FAIL confreg_readback: got %h expected 002", cap[8:0]);
    end
  endtask

  task automatic test_memreg_idle();
    logic [65:0] cap;
    logic [3:0]  irc;
    shift_ir(4'b0100, irc);
    mem_scan(1'b0, 32'h0, 32'h0, 1'b0, cap);
    vectors++;
    if (cap !== 66'h0) begin
      miscompares++;
      $display("FAIL memreg_idle: got %h expected 0", cap);
    end
  endtask

  task automatic test_mem_write();
    logic [65:0] cap;
    bit ok;
    mem_scan(1'b1, 32'h0, 32'hABBA_ABBA, 1'b1, cap);
    poll_valid(cap, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL write_valid: got 0 expected 1 within %0d polls", POLL_MAX);
    end
    vectors++;
    if (cap[32:1] !== 32'h0 || cap[65] !== 1'b0) begin
      miscompares++;
      $display("FAIL write_addr: got %h/%b expected 00000000/0", cap[32:1], cap[65]);
    end
  endtask

  task automatic test_mem_read();
    logic [65:0] cap;
    bit ok;
    mem_scan(1'b0, 32'h0, 32'h0, 1'b1, cap);
    poll_valid(cap, ok);
    vectors++;
    if (!ok || cap[64:33] !== 32'hABBA_ABBA) begin
      miscompares++;
      $display("FAIL read_data: got %h (valid %b) expected abbaabba", cap[64:33], ok);
    end
  endtask

  task automatic test_dropped();
    logic [65:0] cap;
    logic [3:0]  irc;
    bit ok;
    shift_ir(4'b0110, irc);
    shift_dr('0, 9, cap);
    shift_ir(4'b0100, irc);
    mem_scan(1'b1, 32'h0, 32'h0, 1'b1, cap);
    repeat (10) @(posedge clk_i);
    #1ns;
    mem_scan(1'b0, 32'h0, 32'h0, 1'b0, cap);
    vectors++;
    if (cap[0] !== 1'b1 || cap[64:33] !== 32'hABBA_ABBA) begin
      miscompares++;
      $display("FAIL dropped_state: got valid %b data %h expected 1 abbaabba", cap[0], cap[64:33]);
    end
    shift_ir(4'b0110, irc);
    shift_dr({57'h0, 9'h002}, 9, cap);
    shift_ir(4'b0100, irc);
    mem_scan(1'b0, 32'h0, 32'h0, 1'b1, cap);
    poll_valid(cap, ok);
    vectors++;
    if (!ok || cap[64:33] !== 32'hABBA_ABBA) begin
      miscompares++;
      $display("FAIL dropped_readback: got %h (valid %b) expected abbaabba", cap[64:33], ok);
    end
  endtask

  task automatic test_wrap();
    logic [65:0] cap;
    bit ok;
    mem_scan(1'b1, 32'h0000_0400, 32'h1234_5678, 1'b1, cap);
    poll_valid(cap, ok);
    vectors++;
    if (!ok || cap[32:1] !== 32'h0000_0400) begin
      miscompares++;
      $display("FAIL wrap_write: got addr %h (valid %b) expected 00000400", cap[32:1], ok);
    end
    mem_scan(1'b0, 32'h0, 32'h0, 1'b1, cap);
    poll_valid(cap, ok);
    vectors++;
    if (!ok || cap[64:33] !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL wrap_read: got %h (valid %b) expected 12345678", cap[64:33], ok);
    end
  endtask

  task automatic test_tap_reset_clears();
    logic [65:0] cap;
    logic [3:0]  irc;
    repeat (5) tms_step(1'b1);
    tms_step(1'b0);
    shift_ir(4'b0100, irc);
    mem_scan(1'b0, 32'h0, 32'h0, 1'b0, cap);
    vectors++;
    if (cap[0] !== 1'b0 || cap[64:33] !== 32'h0) begin
      miscompares++;
      $display("FAIL tlr_memreg: got valid %b data %h expected 0 00000000", cap[0], cap[64:33]);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_confreg();
    test_memreg_idle();
    test_mem_write();
    test_mem_read();
    test_dropped();
    test_wrap();
    test_tap_reset_clears();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
